// File: rtl/btn_debounce.sv
// Debounces N active-low pushbuttons against the shared 1 kHz tick and emits
// clean levels, press/release/long strobes and a per-button toggle.
// Long-press detection is compiled in only when BTN_LONG_PRESS_EN is defined.
module btn_debounce #(
  parameter int N       = 4,
  parameter int DB_MS   = 20,
  parameter int LONG_MS = 1000
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_pls_1k,
  input  logic [N-1:0] i_btn_n,
  output logic [N-1:0] o_btn_lvl,
  output logic [N-1:0] o_press,
  output logic [N-1:0] o_release,
  output logic [N-1:0] o_go,
  output logic [N-1:0] o_long
);

  localparam int CW = $clog2(DB_MS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_MS - 1);

  if (DB_MS < 2 || DB_MS > 1023 || LONG_MS <= DB_MS) begin : g_param_err
    $error("btn_debounce: illegal DB_MS/LONG_MS combination");
  end

  logic [N-1:0]  sync1_q, sync2_q;
  logic [N-1:0]  s;
  logic [N-1:0]  lvl_q, lvl_d, lvl_dly_q;
  logic [N-1:0]  press_q, release_q, go_q;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  assign s = ~sync2_q;

  // NOTE: every output of this block gets a default before any branch so no latch is inferred.
  always_comb begin
    lvl_d = lvl_q;
    for (int k = 0; k < N; k++) begin
      cnt_d[k] = '0;
      if (s[k] != lvl_q[k]) begin
        cnt_d[k] = cnt_q[k];
        if (i_pls_1k) begin
          if (cnt_q[k] == CNT_LAST) begin
            lvl_d[k] = s[k];
            cnt_d[k] = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments; the counter array is
  // reset too, because a stale count would shorten the first debounce window.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      go_q      <= '0;
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q   <= i_btn_n;
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      press_q   <= lvl_q & ~lvl_dly_q;
      release_q <= ~lvl_q & lvl_dly_q;
      go_q      <= go_q ^ (lvl_q & ~lvl_dly_q);
      for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign o_btn_lvl = lvl_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_go      = go_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_MS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_MS);

  logic [HW-1:0] hold_q [N];
  logic [HW-1:0] hold_d [N];
  logic [N-1:0]  long_q, long_d;

  // Hold counter saturates at LONG_MS so the strobe fires once per press.
  always_comb begin
    long_d = '0;
    for (int k = 0; k < N; k++) begin
      hold_d[k] = '0;
      if (lvl_q[k]) begin
        hold_d[k] = hold_q[k];
        if (i_pls_1k && hold_q[k] != HOLD_MAX) hold_d[k] = hold_q[k] + 1'b1;
      end
      long_d[k] = (hold_d[k] == HOLD_MAX) && (hold_q[k] != HOLD_MAX);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      long_q <= '0;
      for (int k = 0; k < N; k++) hold_q[k] <= '0;
    end else begin
      long_q <= long_d;
      for (int k = 0; k < N; k++) hold_q[k] <= hold_d[k];
    end
  end

  assign o_long = long_q;
`else
  assign o_long = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: strobes are predicted into a scoreboard
// when ticks are driven and matched cycle-exactly when the DUT emits them.
module tb_btn_debounce;

  localparam int N       = 4;
  localparam int DB_MS   = 20;
  localparam int LONG_MS = 1000;

  logic         i_clk = 1'b0;
  logic         i_rstn;
  logic         i_pls_1k;
  logic [N-1:0] i_btn_n;
  logic [N-1:0] o_btn_lvl, o_press, o_release, o_go, o_long;

  btn_debounce #(.N(N), .DB_MS(DB_MS), .LONG_MS(LONG_MS)) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_pls_1k  (i_pls_1k),
    .i_btn_n   (i_btn_n),
    .o_btn_lvl (o_btn_lvl),
    .o_press   (o_press),
    .o_release (o_release),
    .o_go      (o_go),
    .o_long    (o_long)
  );

  always #5 i_clk = ~i_clk;

  typedef enum logic [1:0] {K_PRESS, K_REL, K_LONG} kind_e;
  typedef struct {
    kind_e kind;
    int    idx;
    int    cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_err = 0;
  logic [N-1:0] go_model = '0;

  always @(posedge i_clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input kind_e k, input int idx, input int lat);
    exp_t e;
    e.kind = k;
    e.idx  = idx;
    e.cyc  = cyc + lat;
    sb.push_back(e);
  endtask

  // One tick every 4 clocks; the tick is consumed at the next rising edge.
  task automatic tick_n(input int n);
    repeat (n) begin
      i_pls_1k = 1'b1;
      @(negedge i_clk);
      i_pls_1k = 1'b0;
      repeat (3) @(negedge i_clk);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge i_clk);
  endtask

  // Drive the masked pins, then verify the level flips exactly on tick DB_MS.
  task automatic debounce(input logic [N-1:0] mask, input bit press, input string tag);
    i_btn_n = press ? (i_btn_n & ~mask) : (i_btn_n | mask);
    settle();
    tick_n(DB_MS - 1);
    check({tag, " lvl before last tick"}, 32'(o_btn_lvl & mask), press ? 32'(0) : 32'(mask));
    for (int k = 0; k < N; k++)
      if (mask[k]) push(press ? K_PRESS : K_REL, k, 2);
    tick_n(1);
    check({tag, " lvl after last tick"}, 32'(o_btn_lvl & mask), press ? 32'(mask) : 32'(0));
  endtask

  // Scoreboard side: any strobe, expected or not, is compared against the queue.
  always @(negedge i_clk) begin
    logic [N-1:0] ep, er, el;
    exp_t e;
    ep = '0; er = '0; el = '0;
    if (!i_rstn) begin
      go_model = '0;
    end else begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) check("strobe missed at cycle", 32'(cyc), 32'(e.cyc));
        else case (e.kind)
          K_PRESS: ep[e.idx] = 1'b1;
          K_REL:   er[e.idx] = 1'b1;
          default: el[e.idx] = 1'b1;
        endcase
      end
      if (|{ep, er, el, o_press, o_release, o_long}) begin
        go_model = go_model ^ ep;
        check("o_press", 32'(o_press), 32'(ep));
        check("o_release", 32'(o_release), 32'(er));
        check("o_long", 32'(o_long), 32'(el));
        check("o_go at strobe", 32'(o_go), 32'(go_model));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rstn   = 1'b0;
    i_pls_1k = 1'b0;
    i_btn_n  = '1;
    repeat (3) @(negedge i_clk);
    check("reset lvl", 32'(o_btn_lvl), 0);
    check("reset press", 32'(o_press), 0);
    check("reset release", 32'(o_release), 0);
    check("reset go", 32'(o_go), 0);
    check("reset long", 32'(o_long), 0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    // Clean press and release of button 0.
    debounce(4'b0001, 1'b1, "clean press b0");
    check("go after clean press", 32'(o_go), 32'h1);
    check("other lvl bits idle", 32'(o_btn_lvl), 32'h1);
    debounce(4'b0001, 1'b0, "release b0");

    // Bounce every 3 ticks for 18 ticks, then hold low.
    for (int i = 0; i < 6; i++) begin
      i_btn_n[0] = i[0];
      tick_n(3);
    end
    check("lvl after bounce", 32'(o_btn_lvl), 0);
    debounce(4'b0001, 1'b1, "press after bounce");
    check("go after second press", 32'(o_go), 0);

    // A one-cycle glitch back to pressed restarts the release window.
    i_btn_n[0] = 1'b1;
    settle();
    tick_n(10);
    i_btn_n[0] = 1'b0;
    @(negedge i_clk);
    i_btn_n[0] = 1'b1;
    settle();
    tick_n(DB_MS - 1);
    check("glitch restarted window", 32'(o_btn_lvl[0]), 1);
    push(K_REL, 0, 2);
    tick_n(1);
    check("release after glitch", 32'(o_btn_lvl[0]), 0);

    // Button 2: press, release, press; toggle goes 1, 1, 0.
    debounce(4'b0100, 1'b1, "b2 press 1");
    check("b2 go after press 1", 32'(o_go), 32'h4);
    debounce(4'b0100, 1'b0, "b2 release");
    check("b2 go after release", 32'(o_go), 32'h4);
    debounce(4'b0100, 1'b1, "b2 press 2");
    check("b2 go after press 2", 32'(o_go), 0);

    // Buttons 1 and 3 pressed 5 ticks apart.
    i_btn_n[1] = 1'b0;
    settle();
    tick_n(5);
    i_btn_n[3] = 1'b0;
    settle();
    tick_n(DB_MS - 6);
    push(K_PRESS, 1, 2);
    tick_n(1);
    check("b1 up, b3 still counting", 32'(o_btn_lvl), 32'h6);
    tick_n(4);
    push(K_PRESS, 3, 2);
    tick_n(1);
    check("b1 and b3 up", 32'(o_btn_lvl), 32'he);
    check("go after staggered", 32'(o_go), 32'ha);

    // Simultaneous release and press of buttons 1 and 3.
    debounce(4'b1010, 1'b0, "b1/b3 release");
    debounce(4'b1010, 1'b1, "b1/b3 press");
    check("go after simultaneous", 32'(o_go), 0);
    debounce(4'b1010, 1'b0, "b1/b3 release 2");

    // Long hold on button 0.
    debounce(4'b0001, 1'b1, "long hold press");
`ifdef BTN_LONG_PRESS_EN
    tick_n(LONG_MS - 1);
    push(K_LONG, 0, 1);
    tick_n(1);
    tick_n(500);
`else
    tick_n(1500);
`endif
    check("long idle at end of hold", 32'(o_long), 0);
    debounce(4'b0001, 1'b0, "long hold release");

    // Reset at tick 10 of a press; buttons 0 and 2 stay held through it.
    i_btn_n[0] = 1'b0;
    settle();
    tick_n(10);
    i_rstn = 1'b0;
    #1;
    check("mid reset lvl", 32'(o_btn_lvl), 0);
    check("mid reset go", 32'(o_go), 0);
    check("mid reset strobes", 32'({o_press, o_release, o_long}), 0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    check("no strobe after reset", 32'({o_press, o_release, o_long}), 0);
    debounce(4'b0101, 1'b1, "held through reset");
    check("go after re-debounce", 32'(o_go), 32'h5);

    repeat (4) @(negedge i_clk);
    check("scoreboard drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
